// File: rtl/ram64x8_arbiter_if.sv
// Request/grant/read-data signals for two requesters plus the shared RAM port.
// slave is the arbiter's view; master is the requesters-plus-RAM environment.
interface ram64x8_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy
    );
endinterface

// File: rtl/ram64x8_arbiter.sv
// Two-requester round-robin arbiter sequencing single-port accesses to ram64x8.
// Reads hold en/addr for an extra cycle because the RAM output is bank-gated by them.
module ram64x8_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ram64x8_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t            state_q, state_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              owner_q, owner_d;   // 1 = B
    logic              last_q, last_d;     // 1 = B won last
    logic              pick_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        en_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        owner_d    = owner_q;
        last_d     = last_q;
        pick_b     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // Under contention the requester that did not win last time goes first
                    pick_b  = bus.b_req && (!bus.a_req || !last_q);
                    we_d    = pick_b ? bus.b_we    : bus.a_we;
                    addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
                    en_d    = 1'b1;
                    a_gnt_d = !pick_b;
                    b_gnt_d = pick_b;
                    owner_d = pick_b;
                    last_d  = pick_b;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    en_d    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (owner_q) begin
                    b_rdata_d  = bus.ram_rdata;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = bus.ram_rdata;
                    a_rvalid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_en    = en_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.a_gnt     = a_gnt_q;
    assign bus.b_gnt     = b_gnt_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ram64x8_arbiter.sv
// Directed bench for ram64x8_arbiter with a behavioural bank-gated 64x8 RAM attached.
module tb_ram64x8_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ram64x8_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram64x8_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Four 16-word banks, each with a registered output, muxed by the live en/addr[5:4]
    logic [7:0] mem    [0:63];
    logic [7:0] bank_q [0:3];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bank_q[bus.ram_addr[5:4]] <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_rdata = bus.ram_en ? bank_q[bus.ram_addr[5:4]] : 8'h00;

    task automatic req_set(input logic is_b, input logic we, input logic [5:0] addr,
                           input logic [7:0] wd);
        if (is_b) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
    endtask

    task automatic write_word(input logic is_b, input logic [5:0] addr, input logic [7:0] wd,
                              output bit ok);
        ok = 1'b0;
        req_set(is_b, 1'b1, addr, wd);
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if ((is_b ? bus.b_gnt : bus.a_gnt) === 1'b1) ok = 1'b1;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {bus.ram_en, bus.ram_we, bus.a_gnt,
                     bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.busy});
        end
        checks++;
        if ({bus.ram_addr, bus.ram_wdata} !== 14'h0) begin
            errors++;
            $display("FAIL reset_cmd: got addr %h wdata %h expected 0/0", bus.ram_addr, bus.ram_wdata);
        end
        checks++;
        if ({bus.a_rdata, bus.b_rdata} !== 16'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.a_rdata, bus.b_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        req_set(1'b0, 1'b1, 6'h25, 8'hA5);
        @(negedge clk);
        checks++;
        if ({bus.a_gnt, bus.b_gnt, bus.ram_en, bus.ram_we, bus.busy, bus.ram_addr, bus.ram_wdata}
            !== {5'b10111, 6'h25, 8'hA5}) begin
            errors++;
            $display("FAIL write_issue: got gnt=%b%b en=%b we=%b busy=%b addr=%h wd=%h expected 10 1 1 1 25 a5",
                     bus.a_gnt, bus.b_gnt, bus.ram_en, bus.ram_we, bus.busy, bus.ram_addr, bus.ram_wdata);
        end
        bus.a_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ram_en, bus.a_gnt, bus.a_rvalid, bus.b_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL write_done: got busy/en/gnt/rv/rv=%b expected 00000",
                     {bus.busy, bus.ram_en, bus.a_gnt, bus.a_rvalid, bus.b_rvalid});
        end
    endtask

    task automatic test_readback();
        logic [5:0] addrs [4];
        logic [7:0] vals  [4];
        bit ok;
        addrs = '{6'h03, 6'h13, 6'h23, 6'h3F};
        vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            write_word(1'b0, addrs[i], vals[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL prewrite[%0d]: got no a_gnt within 8 cycles, expected grant", i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            req_set(1'b1, 1'b0, addrs[i], 8'h00);
            @(negedge clk);
            checks++;
            if ({bus.b_gnt, bus.ram_en, bus.ram_we, bus.ram_addr} !== {3'b110, addrs[i]}) begin
                errors++;
                $display("FAIL read_acc[%0d]: got gnt/en/we=%b%b%b addr=%h expected 110 %h",
                         i, bus.b_gnt, bus.ram_en, bus.ram_we, bus.ram_addr, addrs[i]);
            end
            bus.b_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.ram_en, bus.ram_addr, bus.b_rvalid, bus.b_gnt} !== {1'b1, addrs[i], 2'b00}) begin
                errors++;
                $display("FAIL read_hold[%0d]: got en=%b addr=%h rv=%b gnt=%b expected 1 %h 0 0",
                         i, bus.ram_en, bus.ram_addr, bus.b_rvalid, bus.b_gnt, addrs[i]);
            end
            @(negedge clk);
            checks++;
            if ({bus.b_rvalid, bus.b_rdata, bus.a_rvalid} !== {1'b1, vals[i], 1'b0}) begin
                errors++;
                $display("FAIL read_data[%0d]: got b_rvalid=%b b_rdata=%h a_rvalid=%b expected 1 %h 0",
                         i, bus.b_rvalid, bus.b_rdata, bus.a_rvalid, vals[i]);
            end
        end
    endtask

    task automatic test_contention();
        logic exp_a, exp_b;
        reset_pulse();
        req_set(1'b0, 1'b1, 6'h30, 8'h01);
        req_set(1'b1, 1'b1, 6'h31, 8'h02);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_a = (i % 4 == 1);
            exp_b = (i % 4 == 3);
            checks++;
            if ({bus.a_gnt, bus.b_gnt} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL contention_gnt[%0d]: got a/b=%b%b expected %b%b",
                         i, bus.a_gnt, bus.b_gnt, exp_a, exp_b);
            end
            if (exp_a || exp_b) begin
                checks++;
                if (bus.ram_addr !== (exp_a ? 6'h30 : 6'h31)) begin
                    errors++;
                    $display("FAIL contention_addr[%0d]: got %h expected %h",
                             i, bus.ram_addr, exp_a ? 6'h30 : 6'h31);
                end
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_interleave();
        reset_pulse();
        req_set(1'b0, 1'b1, 6'h10, 8'h5A);
        req_set(1'b1, 1'b0, 6'h10, 8'h00);
        @(negedge clk);
        checks++;
        if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL interleave_first: got a/b gnt=%b%b expected 10", bus.a_gnt, bus.b_gnt);
        end
        bus.a_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.a_gnt, bus.b_gnt, bus.ram_we, bus.ram_addr} !== {3'b010, 6'h10}) begin
            errors++;
            $display("FAIL interleave_second: got gnt=%b%b we=%b addr=%h expected 01 0 10",
                     bus.a_gnt, bus.b_gnt, bus.ram_we, bus.ram_addr);
        end
        bus.b_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.b_rvalid, bus.b_rdata, bus.a_rvalid} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL interleave_data: got b_rvalid=%b b_rdata=%h a_rvalid=%b expected 1 5a 0",
                     bus.b_rvalid, bus.b_rdata, bus.a_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        req_set(1'b0, 1'b0, 6'h03, 8'h00);
        @(negedge clk);
        checks++;
        if (bus.a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got a_gnt=%b expected 1", bus.a_gnt);
        end
        bus.a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ram_en, bus.ram_we, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.busy} !== 7'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: got %b expected 0000000", {bus.ram_en, bus.ram_we, bus.a_gnt,
                     bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.busy});
        end
        checks++;
        if ({bus.ram_addr, bus.ram_wdata, bus.a_rdata, bus.b_rdata} !== 30'h0) begin
            errors++;
            $display("FAIL midrst_data: got addr=%h wd=%h ard=%h brd=%h expected all 0",
                     bus.ram_addr, bus.ram_wdata, bus.a_rdata, bus.b_rdata);
        end
        rst_n = 1'b1;
        req_set(1'b0, 1'b1, 6'h38, 8'hEE);
        req_set(1'b1, 1'b1, 6'h39, 8'h77);
        @(negedge clk);
        checks++;
        if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_rr: got a_gnt=%b b_gnt=%b a_rvalid=%b expected 1 0 0",
                     bus.a_gnt, bus.b_gnt, bus.a_rvalid);
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_late_release();
        req_set(1'b0, 1'b0, 6'h13, 8'h00);
        @(negedge clk);
        checks++;
        if ({bus.a_gnt, bus.ram_addr} !== {1'b1, 6'h13}) begin
            errors++;
            $display("FAIL late_gnt1: got gnt=%b addr=%h expected 1 13", bus.a_gnt, bus.ram_addr);
        end
        bus.a_addr = 6'h23;
        @(negedge clk);
        checks++;
        if ({bus.ram_en, bus.ram_addr, bus.a_gnt} !== {1'b1, 6'h13, 1'b0}) begin
            errors++;
            $display("FAIL late_hold: got en=%b addr=%h gnt=%b expected 1 13 0",
                     bus.ram_en, bus.ram_addr, bus.a_gnt);
        end
        @(negedge clk);
        checks++;
        if ({bus.a_rvalid, bus.a_rdata, bus.busy, bus.ram_en, bus.a_gnt} !== {1'b1, 8'h22, 3'b000}) begin
            errors++;
            $display("FAIL late_data1: got rv=%b rd=%h busy=%b en=%b gnt=%b expected 1 22 0 0 0",
                     bus.a_rvalid, bus.a_rdata, bus.busy, bus.ram_en, bus.a_gnt);
        end
        @(negedge clk);
        checks++;
        if ({bus.a_gnt, bus.ram_addr} !== {1'b1, 6'h23}) begin
            errors++;
            $display("FAIL late_gnt2: got gnt=%b addr=%h expected 1 23", bus.a_gnt, bus.ram_addr);
        end
        bus.a_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.a_rvalid, bus.a_rdata, bus.b_rvalid} !== {1'b1, 8'h33, 1'b0}) begin
            errors++;
            $display("FAIL late_data2: got rv=%b rd=%h b_rv=%b expected 1 33 0",
                     bus.a_rvalid, bus.a_rdata, bus.b_rvalid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_readback();
        test_contention();
        test_interleave();
        test_reset_mid_read();
        test_late_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
